// File: rtl/adder_share_arb.sv
// Two-requester arbiter around one shared 32-bit carry-lookahead adder.
// Optional round-robin tie-breaking is enabled with `define ADDER_ARB_RR_EN.

module cla32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum
);

  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] c;
  logic [7:0]  gg;
  logic [7:0]  gp;
  logic [7:0]  gc;

  assign g = a & b;
  assign p = a ^ b;

  // Per-nibble group generate/propagate terms.
  always_comb begin
    gg = '0;
    gp = '0;
    for (int k = 0; k < 8; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
  end

  // Group carry-in chain; the carry out of the top group is not needed.
  always_comb begin
    logic acc;
    gc  = '0;
    acc = cin;
    for (int k = 0; k < 8; k++) begin
      gc[k] = acc;
      acc   = gg[k] | (gp[k] & acc);
    end
  end

  // Bit carries inside each nibble from the group carry-in.
  always_comb begin
    c = '0;
    for (int k = 0; k < 8; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k]
               | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1]
               | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2]
               | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
  end

  assign sum = p ^ c;

endmodule

module adder_share_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_cin,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_cin,
  output logic        req1_ready,
  output logic        out_valid,
  output logic [31:0] out_sum,
  output logic        out_id,
  input  logic        out_ready
);

  typedef enum logic {
    LAST0 = 1'b0,
    LAST1 = 1'b1
  } arb_t;

  arb_t        state;
  arb_t        state_nxt;
  logic        tie_to1;
  logic        slot_free;
  logic        grant0;
  logic        grant1;
  logic        xfer;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] add_sum;

  assign slot_free = !out_valid || out_ready;
  assign xfer      = grant0 || grant1;

  // Arbitration state register: remembers the last granted requester.
  always_ff @(posedge clk) begin
    if (rst) state <= LAST1;
    else     state <= state_nxt;
  end

  // Next-state: move only when a transfer happens.
  always_comb begin
    state_nxt = state;
    if (grant0)      state_nxt = LAST0;
    else if (grant1) state_nxt = LAST1;
  end

  // FSM output: which requester wins when both are valid.
`ifdef ADDER_ARB_RR_EN
  always_comb begin
    tie_to1 = (state == LAST0);
  end
`else
  always_comb begin
    tie_to1 = 1'b0;
  end
`endif

  // Grant decode; nothing is granted in reset or while the slot is held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && slot_free) begin
      priority case (1'b1)
        (req0_valid && req1_valid): begin
          grant0 = !tie_to1;
          grant1 = tie_to1;
        end
        req0_valid: grant0 = 1'b1;
        req1_valid: grant1 = 1'b1;
        default: ;
      endcase
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Steer the granted requester's operands into the shared adder.
  always_comb begin
    add_a   = req0_a;
    add_b   = req0_b;
    add_cin = req0_cin;
    if (grant1) begin
      add_a   = req1_a;
      add_b   = req1_b;
      add_cin = req1_cin;
    end
  end

  cla32 u_cla (
    .a   (add_a),
    .b   (add_b),
    .cin (add_cin),
    .sum (add_sum)
  );

  // Result slot: load on transfer, drain when consumed, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_id    <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_sum   <= add_sum;
      out_id    <= grant1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_share_arb.sv
// Bench for adder_share_arb: directed vector table plus randomized
// traffic checked against a behavioural model.

module tb_adder_share_arb;

`ifdef ADDER_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_cin, req0_ready;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_cin, req1_ready;
  logic [31:0] req1_a, req1_b;
  logic        out_valid, out_id, out_ready;
  logic [31:0] out_sum;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  adder_share_arb dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_sum    (out_sum),
    .out_id     (out_id),
    .out_ready  (out_ready)
  );

  typedef struct {
    bit        rst;
    bit        v0;
    bit [31:0] a0;
    bit [31:0] b0;
    bit        c0;
    bit        v1;
    bit [31:0] a1;
    bit [31:0] b1;
    bit        c1;
    bit        ordy;
    bit        r0;
    bit        r1;
    bit        ov;
    bit [31:0] sum;
    bit        id;
  } vec_t;

  vec_t tbl[$];

  task automatic cmp(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit v0, input bit [31:0] a0,
                       input bit [31:0] b0, input bit c0, input bit v1,
                       input bit [31:0] a1, input bit [31:0] b1,
                       input bit c1, input bit ordy);
    rst = r;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_cin = c0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_cin = c1;
    out_ready = ordy;
  endtask

  function automatic vec_t mk(bit r, bit v0, bit [31:0] a0, bit [31:0] b0,
                              bit c0, bit v1, bit [31:0] a1, bit [31:0] b1,
                              bit c1, bit ordy, bit r0, bit r1, bit ov,
                              bit [31:0] sum, bit id);
    vec_t v;
    v.rst = r; v.v0 = v0; v.a0 = a0; v.b0 = b0; v.c0 = c0;
    v.v1 = v1; v.a1 = a1; v.b1 = b1; v.c1 = c1; v.ordy = ordy;
    v.r0 = r0; v.r1 = r1; v.ov = ov; v.sum = sum; v.id = id;
    return v;
  endfunction

  // Behavioural model state
  bit        m_ov;
  bit [31:0] m_sum;
  bit        m_id;
  int        m_last;

  function automatic bit [31:0] add32(bit [31:0] a, bit [31:0] b, bit c);
    bit [32:0] t;
    t = {1'b0, a} + {1'b0, b} + {32'd0, c};
    return t[31:0];
  endfunction

  initial begin
    bit        v0, v1, c0, c1, ordy, r;
    bit [31:0] a0, b0, a1, b1;
    bit        hold0, hold1;
    int        win, tie;

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    // Directed table: each row's outputs reflect the state before its edge.
    tbl.push_back(mk(0, 1, 32'h0040_0000, 4, 0, 0, 0, 0, 0, 1,
                     1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF, 1, 0, 1,
                     0, 1, 1, 32'h0040_0004, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                     0, 0, 1, 32'h0, 1));
    tbl.push_back(mk(0, 1, 1, 2, 0, 1, 10, 20, 1, 1,
                     1, 0, 0, 32'h0, 1));
    tbl.push_back(mk(0, 1, 1, 2, 0, 1, 10, 20, 1, 1,
                     !RR, RR, 1, 3, 0));
    tbl.push_back(mk(0, 1, 1, 2, 0, 1, 10, 20, 1, 1,
                     1, 0, 1, RR ? 32'd31 : 32'd3, RR));
    tbl.push_back(mk(0, 1, 1, 2, 0, 1, 10, 20, 1, 1,
                     !RR, RR, 1, 3, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                     0, 0, 1, RR ? 32'd31 : 32'd3, RR));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                     0, 0, 0, RR ? 32'd31 : 32'd3, RR));
    tbl.push_back(mk(0, 1, 100, 1, 0, 0, 0, 0, 0, 1,
                     1, 0, 0, RR ? 32'd31 : 32'd3, RR));
    tbl.push_back(mk(0, 1, 200, 2, 1, 0, 0, 0, 0, 1,
                     1, 0, 1, 101, 0));
    tbl.push_back(mk(0, 1, 32'h7FFF_FFFF, 1, 0, 0, 0, 0, 0, 1,
                     1, 0, 1, 203, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                     0, 0, 1, 32'h8000_0000, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 32'h8000_0000, 0));
    tbl.push_back(mk(0, 1, 5, 6, 1, 0, 0, 0, 0, 0,
                     1, 0, 0, 32'h8000_0000, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 1, 7, 8, 0, 0, 0, 0, 0, 0,
                       0, 0, 1, 12, 0));
    tbl.push_back(mk(0, 1, 7, 8, 0, 0, 0, 0, 0, 1,
                     1, 0, 1, 12, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 1, 15, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 9, 9, 0, 0,
                     0, 0, 1, 15, 0));
    tbl.push_back(mk(0, 1, 1, 2, 0, 1, 10, 20, 1, 1,
                     1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                     0, 0, 1, 3, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].v0, tbl[i].a0, tbl[i].b0, tbl[i].c0,
            tbl[i].v1, tbl[i].a1, tbl[i].b1, tbl[i].c1, tbl[i].ordy);
      #4;
      cmp($sformatf("row%0d req0_ready", i), 32'(req0_ready), 32'(tbl[i].r0));
      cmp($sformatf("row%0d req1_ready", i), 32'(req1_ready), 32'(tbl[i].r1));
      cmp($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      cmp($sformatf("row%0d out_sum", i), out_sum, tbl[i].sum);
      cmp($sformatf("row%0d out_id", i), 32'(out_id), 32'(tbl[i].id));
      @(posedge clk);
      #1;
    end

    // Randomized traffic against the model, starting from a reset.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    m_ov = 0; m_sum = 0; m_id = 0; m_last = 1;
    hold0 = 0; hold1 = 0;
    a0 = 0; b0 = 0; c0 = 0; a1 = 0; b1 = 0; c1 = 0;
    for (int n = 0; n < 400; n++) begin
      r = ($urandom_range(0, 39) == 0);
      if (!hold0) begin
        v0 = $urandom_range(0, 2) != 0;
        a0 = $urandom; b0 = $urandom; c0 = $urandom_range(0, 1);
        if ($urandom_range(0, 7) == 0) begin a0 = '1; b0 = 1; end
      end
      if (!hold1) begin
        v1 = $urandom_range(0, 2) != 0;
        a1 = $urandom; b1 = $urandom; c1 = $urandom_range(0, 1);
      end
      ordy = $urandom_range(0, 3) != 0;
      drive(r, v0, a0, b0, c0, v1, a1, b1, c1, ordy);
      #4;
      win = -1;
      tie = (RR && m_last == 0) ? 1 : 0;
      if (!r && (!m_ov || ordy)) begin
        if (v0 && v1) win = tie;
        else if (v0)  win = 0;
        else if (v1)  win = 1;
      end
      cmp("rnd req0_ready", 32'(req0_ready), 32'(win == 0));
      cmp("rnd req1_ready", 32'(req1_ready), 32'(win == 1));
      cmp("rnd out_valid", 32'(out_valid), 32'(m_ov));
      cmp("rnd out_sum", out_sum, m_sum);
      cmp("rnd out_id", 32'(out_id), 32'(m_id));
      if (r) begin
        m_ov = 0; m_sum = 0; m_id = 0; m_last = 1;
      end else if (win == 0) begin
        m_ov = 1; m_sum = add32(a0, b0, c0); m_id = 0; m_last = 0;
      end else if (win == 1) begin
        m_ov = 1; m_sum = add32(a1, b1, c1); m_id = 1; m_last = 1;
      end else if (ordy) begin
        m_ov = 0;
      end
      hold0 = v0 && win != 0 && !r;
      hold1 = v1 && win != 1 && !r;
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
